// File: rtl/seq_divider_pkg.sv
// Shared divider package: FSM state encoding, pipeline word types and sizing helpers.
package seq_divider_pkg;

   localparam int unsigned DIV_WIDTH = 32;

   typedef logic [31:0] i32;
   typedef logic [63:0] i64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Iteration counter width; one spare bit so a full operation never wraps.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration: shift in the dividend MSB, trial-subtract the divisor.
module div_step
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_msb,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_trial;
   logic             w_unused;

   assign w_shift = {i_rem, i_msb};
   assign w_trial = {1'b0, w_shift} - {2'b00, i_divisor};

   // A clear sign bit means the trial difference is non-negative.
   assign o_qbit = ~w_trial[WIDTH+1];
   assign o_rem  = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

   // Upper bits only matter for a zero divisor, where truncation is the intended result.
   assign w_unused = ^{w_trial[WIDTH], w_shift[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, responder side of execute's valid/done handshake.
// Define SEQ_DIVIDER_OPERAND_CHECK_EN to restart when live operands change during BUSY.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               valid,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] c
);

   localparam int unsigned      CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   div_state_t         r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_count, w_count_nxt;
   logic [WIDTH-1:0]   r_rem, w_rem_nxt;
   logic [WIDTH-1:0]   r_quo, w_quo_nxt;
   logic [WIDTH-1:0]   r_divisor, w_divisor_nxt;
   logic               r_done, w_done_nxt;
   logic [2*WIDTH-1:0] r_c, w_c_nxt;

   logic [WIDTH-1:0]   w_step_rem;
   logic               w_step_qbit;
   logic [WIDTH-1:0]   w_quo_shift;

`ifdef SEQ_DIVIDER_OPERAND_CHECK_EN
   logic [WIDTH-1:0]   r_a, w_a_nxt;
   logic               w_restart;

   assign w_restart = (a != r_a) || (b != r_divisor);
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (r_rem),
      .i_msb     (r_quo[WIDTH-1]),
      .i_divisor (r_divisor),
      .o_rem     (w_step_rem),
      .o_qbit    (w_step_qbit)
   );

   // Dividend shifts out at the top while quotient bits fill in from the bottom.
   assign w_quo_shift = {r_quo[WIDTH-2:0], w_step_qbit};

   // Next-state and next-register values.
   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_rem_nxt     = r_rem;
      w_quo_nxt     = r_quo;
      w_divisor_nxt = r_divisor;
      w_done_nxt    = 1'b0;
      w_c_nxt       = '0;
`ifdef SEQ_DIVIDER_OPERAND_CHECK_EN
      w_a_nxt       = r_a;
`endif

      case (r_state)
         IDLE: begin
            if (valid) begin
               w_state_nxt   = BUSY;
               w_count_nxt   = '0;
               w_rem_nxt     = '0;
               w_quo_nxt     = a;
               w_divisor_nxt = b;
`ifdef SEQ_DIVIDER_OPERAND_CHECK_EN
               w_a_nxt       = a;
`endif
            end
         end

         BUSY: begin
            if (!valid) begin
               w_state_nxt = IDLE;
`ifdef SEQ_DIVIDER_OPERAND_CHECK_EN
            end else if (w_restart) begin
               w_count_nxt   = '0;
               w_rem_nxt     = '0;
               w_quo_nxt     = a;
               w_divisor_nxt = b;
               w_a_nxt       = a;
`endif
            end else begin
               w_rem_nxt   = w_step_rem;
               w_quo_nxt   = w_quo_shift;
               w_count_nxt = r_count + CNT_W'(1);
               if (r_count == LAST) begin
                  w_state_nxt = DONE;
                  w_done_nxt  = 1'b1;
                  w_c_nxt     = {w_step_rem, w_quo_shift};
               end
            end
         end

         DONE: begin
            w_state_nxt = IDLE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_done    <= 1'b0;
         r_c       <= '0;
`ifdef SEQ_DIVIDER_OPERAND_CHECK_EN
         r_a       <= '0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_rem     <= w_rem_nxt;
         r_quo     <= w_quo_nxt;
         r_divisor <= w_divisor_nxt;
         r_done    <= w_done_nxt;
         r_c       <= w_c_nxt;
`ifdef SEQ_DIVIDER_OPERAND_CHECK_EN
         r_a       <= w_a_nxt;
`endif
      end
   end

   assign done = r_done;
   assign c    = r_c;

endmodule
